sequenciador_menor_custo: RTL and testbench
===========================================

// Module: sequenciador_menor_custo
// PURPOSE
//  Controller for the min-comparator (comparador_na): finds the smallest cost among
//  NUM_PALAVRAS*NUM_COMPARADOR entries in a banked cost memory, plus the index of its first occurrence.
//  Two passes:
//  - Pass 1 streams every memory word through the comparator.
//  - Pass 2 rescans the memory against the latched minimum to find the index.
//  The all-ones value means "infinite/invalid". Sits between the cost RAM and the node-selection logic.
// PARAMETERS
//  DATA_WIDTH      8   width of one cost entry
//  NUM_COMPARADOR  8   entries per memory word (comparator lanes)
//  NUM_PALAVRAS    16  memory words scanned per search (>=1)
//  ADDR_WIDTH      4   memory address width, >= clog2(NUM_PALAVRAS)
//  IDX_WIDTH       7   result index width, >= clog2(NUM_PALAVRAS*NUM_COMPARADOR)
// PORTS
//  clk                 in   1                            clock
//  rst_n               in   1                            async active-low reset
//  start_in            in   1                            start search (sampled in IDLE only)
//  busy_out            out  1                            high from the cycle after start until done
//  done_out            out  1                            1-cycle pulse, results valid
//  rd_en_out           out  1                            memory read strobe
//  rd_addr_out         out  ADDR_WIDTH                   memory word address
//  rd_data_in          in   DATA_WIDTH*NUM_COMPARADOR    word, valid 1 cycle after rd_en; lane i = bits [DW*i+DW-1:DW*i]
//  cmp_iniciar_out     out  1                            comparator clear (to all-ones)
//  cmp_atualizar_out   out  1                            high when cmp_data_out carries valid data
//  cmp_data_out        out  DATA_WIDTH*NUM_COMPARADOR    comparator input bus
//  cmp_min_in          in   DATA_WIDTH                   comparator registered running minimum
//  min_out             out  DATA_WIDTH                   minimum found
//  idx_out             out  IDX_WIDTH                    word*NUM_COMPARADOR+lane of first match
//  found_out           out  1                            1 if min_out != all-ones
// BEHAVIOUR
//  Reset:
//  - FSM=IDLE; busy/done/rd_en/cmp_iniciar/cmp_atualizar/found = 0.
//  - rd_addr = 0; idx = 0; min_out = all-ones; cmp_data_out = all-ones.
//  Comparator contract:
//  - Captures min(cmp_min, every lane) on every edge unless iniciar is high.
//  - The controller drives cmp_data_out = all-ones whenever its data is not valid.
//  FSM IDLE->CLEAR->SCAN->DRAIN->(LOCATE)->DONE->IDLE; start_in sampled at cycle 0.
//  - CLEAR (cycle 1): cmp_iniciar=1 for exactly one cycle.
//  - SCAN (cycles 2..P+1, P=NUM_PALAVRAS): rd_en=1, rd_addr=k in cycle 2+k.
//    A registered valid flag gates rd_data onto cmp_data_out in cycle 3+k; cmp_atualizar=1 then.
//  - DRAIN (cycles P+2, P+3): no reads; min_out <= cmp_min_in at end of P+3.
//    If cmp_min_in == all-ones: found=0, idx=0, go DONE.
//  - LOCATE: reissue reads from addr 0; compare each returned lane to min_out.
//    On the first hit (lowest addr, then lowest lane): idx <= addr*NUM_COMPARADOR+lane, found=1, go DONE.
//    Reads stop after addr P-1; one speculative read past the hit is allowed, and its data is ignored.
//    No hit is impossible by construction; still go DONE with found=0.
//  - DONE: done_out=1 for one cycle, busy drops the same cycle, return to IDLE.
//  Outputs:
//  - min_out/idx_out/found_out hold until the next search latches them.
//  - They are not cleared on start.
//  Boundaries:
//  - start_in while busy: ignored.
//  - start_in in the DONE cycle: ignored.
//  - start_in held high: a new search starts from IDLE on the next cycle.
//  - NUM_PALAVRAS=1: SCAN is 1 cycle.
//  - rd_addr saturates at P-1; it never wraps within a pass.
//  - Ties: the lowest index wins.
//  - Entries equal to all-ones never produce found=1.
//  - rst_n low mid-search: immediate return to the reset state.
//    No done pulse; the comparator is cleared by the next CLEAR.
//  Latency:
//  - not found: done in cycle P+4.
//  - hit at word j: done in cycle P+6+j.
// TESTING
//  1. DW=8,NC=8,P=16; entry n = 200-n, entry 77 = 5 -> min=5, idx=77, found=1, done at cycle 22+9=31.
//  2. All entries 8'hFF -> found=0, idx=0, min=8'hFF, done at cycle P+4=20; no LOCATE reads.
//  3. Value 3 at indices 10 and 90, rest 50 -> idx=10 (first wins); LOCATE stops at word 1.
//  4. start_in pulsed at cycles 5 and 12 of a running search -> ignored, single done pulse.
//  5. rst_n low in cycle 8 of SCAN -> all outputs return to reset values.
//     New start yields the correct result, unaffected by stale comparator state.
//  6. Min in the last lane of the last word (idx 127=1) -> idx=127, done at cycle 16+6+15=37.

Source files
------------

// File: rtl/sequenciador_menor_custo_if.sv
// Memory-read and min-comparator bus between the minimum-cost sequencer (master)
// and the cost RAM / comparator pair (slave).
interface sequenciador_menor_custo_if #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned NUM_COMPARADOR = 8,
   parameter int unsigned ADDR_WIDTH     = 4
);
   logic                                 rd_en_out;
   logic [ADDR_WIDTH-1:0]                rd_addr_out;
   logic [DATA_WIDTH*NUM_COMPARADOR-1:0] rd_data_in;
   logic                                 cmp_iniciar_out;
   logic                                 cmp_atualizar_out;
   logic [DATA_WIDTH*NUM_COMPARADOR-1:0] cmp_data_out;
   logic [DATA_WIDTH-1:0]                cmp_min_in;

   modport master (
      output rd_en_out, rd_addr_out, cmp_iniciar_out, cmp_atualizar_out, cmp_data_out,
      input  rd_data_in, cmp_min_in
   );

   modport slave (
      input  rd_en_out, rd_addr_out, cmp_iniciar_out, cmp_atualizar_out, cmp_data_out,
      output rd_data_in, cmp_min_in
   );
endinterface

// File: rtl/sequenciador_menor_custo.sv
// Two-pass minimum-cost search: pass 1 streams the cost RAM through the comparator,
// pass 2 rescans it to locate the first entry equal to the latched minimum.
module sequenciador_menor_custo #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned NUM_COMPARADOR = 8,
   parameter int unsigned NUM_PALAVRAS   = 16,
   parameter int unsigned ADDR_WIDTH     = 4,
   parameter int unsigned IDX_WIDTH      = 7
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start_in,
   output logic                        busy_out,
   output logic                        done_out,
   sequenciador_menor_custo_if.master  bus,
   output logic [DATA_WIDTH-1:0]       min_out,
   output logic [IDX_WIDTH-1:0]        idx_out,
   output logic                        found_out
);

   typedef enum logic [2:0] {IDLE, CLEAR, SCAN, DRAIN, LOCATE, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PALAVRAS - 1);
   localparam logic [DATA_WIDTH-1:0] INF       = '1;

   state_t                  state, state_nx;
   logic [ADDR_WIDTH-1:0]   rd_addr_q;
   logic [ADDR_WIDTH-1:0]   data_addr_q;
   logic                    scan_vld_q;
   logic                    loc_vld_q;
   logic                    drain_q;
   logic                    issued_all_q;
   logic                    rd_en;
   logic                    hit;
   logic [IDX_WIDTH-1:0]    hit_lane;

   // Lowest lane wins on ties, so the first match in scan order is kept.
   always_comb begin
      hit      = 1'b0;
      hit_lane = '0;
      for (int unsigned i = 0; i < NUM_COMPARADOR; i++) begin
         if (!hit && bus.rd_data_in[DATA_WIDTH*i +: DATA_WIDTH] == min_out) begin
            hit      = 1'b1;
            hit_lane = IDX_WIDTH'(i);
         end
      end
   end

   always_comb begin
      rd_en    = (state == SCAN) || (state == LOCATE && !issued_all_q);
      state_nx = state;
      case (state)
         IDLE:   if (start_in) state_nx = CLEAR;
         CLEAR:  state_nx = SCAN;
         SCAN:   if (rd_addr_q == LAST_ADDR) state_nx = DRAIN;
         DRAIN:  if (drain_q) state_nx = (bus.cmp_min_in == INF) ? DONE : LOCATE;
         LOCATE: if (loc_vld_q && (hit || data_addr_q == LAST_ADDR)) state_nx = DONE;
         DONE:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy_out              = (state == CLEAR) || (state == SCAN) ||
                                  (state == DRAIN) || (state == LOCATE);
   assign done_out              = (state == DONE);
   assign bus.rd_en_out         = rd_en;
   assign bus.rd_addr_out       = rd_addr_q;
   assign bus.cmp_iniciar_out   = (state == CLEAR);
   assign bus.cmp_atualizar_out = scan_vld_q;
   assign bus.cmp_data_out      = scan_vld_q ? bus.rd_data_in : '1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         rd_addr_q    <= '0;
         data_addr_q  <= '0;
         scan_vld_q   <= 1'b0;
         loc_vld_q    <= 1'b0;
         drain_q      <= 1'b0;
         issued_all_q <= 1'b0;
         min_out      <= '1;
         idx_out      <= '0;
         found_out    <= 1'b0;
      end else begin
         state       <= state_nx;
         scan_vld_q  <= (state == SCAN);
         loc_vld_q   <= (state == LOCATE) && rd_en;
         data_addr_q <= rd_addr_q;
         drain_q     <= (state == DRAIN) && !drain_q;

         if (state != SCAN && state != LOCATE)
            rd_addr_q <= '0;
         else if (rd_en && rd_addr_q != LAST_ADDR)
            rd_addr_q <= rd_addr_q + 1'b1;

         // Saturated address alone cannot tell whether the last word was issued.
         if (state != LOCATE)
            issued_all_q <= 1'b0;
         else if (rd_en && rd_addr_q == LAST_ADDR)
            issued_all_q <= 1'b1;

         if (state == DRAIN && drain_q) begin
            min_out <= bus.cmp_min_in;
            if (bus.cmp_min_in == INF) begin
               found_out <= 1'b0;
               idx_out   <= '0;
            end
         end

         if (state == LOCATE && loc_vld_q) begin
            if (hit) begin
               idx_out   <= IDX_WIDTH'(data_addr_q) * IDX_WIDTH'(NUM_COMPARADOR) + hit_lane;
               found_out <= 1'b1;
            end else if (data_addr_q == LAST_ADDR) begin
               idx_out   <= '0;
               found_out <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sequenciador_menor_custo.sv
// Directed bench for sequenciador_menor_custo with a behavioural cost RAM and
// min-comparator on the slave side of the bus.
module tb_sequenciador_menor_custo;

   localparam int P = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_in = 1'b0;
   logic       busy_out, done_out, found_out;
   logic [7:0] min_out;
   logic [6:0] idx_out;

   sequenciador_menor_custo_if #(.DATA_WIDTH(8), .NUM_COMPARADOR(8), .ADDR_WIDTH(4)) bus ();

   sequenciador_menor_custo #(
      .DATA_WIDTH(8), .NUM_COMPARADOR(8), .NUM_PALAVRAS(16), .ADDR_WIDTH(4), .IDX_WIDTH(7)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_in(start_in), .busy_out(busy_out),
      .done_out(done_out), .bus(bus), .min_out(min_out), .idx_out(idx_out),
      .found_out(found_out)
   );

   always #5 clk = ~clk;

   logic [63:0] mem [P];
   logic [63:0] rd_data_q = '0;
   logic [7:0]  cmp_min_q = 8'h00;

   assign bus.rd_data_in = rd_data_q;
   assign bus.cmp_min_in = cmp_min_q;

   function automatic logic [7:0] lane_min(input logic [7:0] m, input logic [63:0] w);
      for (int i = 0; i < 8; i++)
         if (w[8*i +: 8] < m) m = w[8*i +: 8];
      return m;
   endfunction

   always @(posedge clk) if (bus.rd_en_out) rd_data_q <= mem[bus.rd_addr_out];

   always @(posedge clk) begin
      if (bus.cmp_iniciar_out) cmp_min_q <= 8'hFF;
      else                     cmp_min_q <= lane_min(cmp_min_q, bus.cmp_data_out);
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fill_all(input logic [7:0] v);
      for (int w = 0; w < P; w++) mem[w] = {8{v}};
   endtask

   task automatic set_entry(input int n, input logic [7:0] v);
      mem[n/8][8*(n%8) +: 8] = v;
   endtask

   task automatic fill_desc();
      for (int n = 0; n < 128; n++) set_entry(n, 8'(200 - n));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"}, busy_out, 0);
      check({tag, "_done"}, done_out, 0);
      check({tag, "_rd_en"}, bus.rd_en_out, 0);
      check({tag, "_rd_addr"}, bus.rd_addr_out, 0);
      check({tag, "_iniciar"}, bus.cmp_iniciar_out, 0);
      check({tag, "_atualizar"}, bus.cmp_atualizar_out, 0);
      check({tag, "_cmp_data"}, bus.cmp_data_out, 64'hFFFF_FFFF_FFFF_FFFF);
      check({tag, "_min"}, min_out, 8'hFF);
      check({tag, "_idx"}, idx_out, 0);
      check({tag, "_found"}, found_out, 0);
   endtask

   // Cycle n = n-th negedge after the edge that samples start (cycle 0).
   task automatic run_search(input int pa, input int pb, input int rst_cyc,
                             output int done_cyc, output int reads, output logic [7:0] min_c1);
      int n;
      int extra;
      n = 0; done_cyc = -1; reads = 0; min_c1 = '0;
      @(negedge clk); start_in = 1'b1;
      @(posedge clk); #1 start_in = 1'b0;
      while (n < 200) begin
         @(negedge clk); n++;
         start_in = (n == pa) || (n == pb);
         if (n == 1) begin
            check("busy_c1", busy_out, 1);
            check("iniciar_c1", bus.cmp_iniciar_out, 1);
            min_c1 = min_out;
         end
         if (n == rst_cyc) begin
            rst_n = 1'b0; #1;
            check_reset_vals("midreset");
            @(negedge clk); rst_n = 1'b1;
            done_cyc = -2;
            return;
         end
         if (bus.rd_en_out) reads++;
         if (done_out) begin
            done_cyc = n;
            check("busy_at_done", busy_out, 0);
            break;
         end
      end
      start_in = 1'b0;
      if (done_cyc < 0) check("timeout", 0, 1);
      else begin
         extra = 0;
         repeat (5) begin @(negedge clk); if (done_out) extra++; end
         check("extra_done", extra, 0);
         check("idle_busy", busy_out, 0);
      end
   endtask

   int         dc, rd, n;
   logic [7:0] mc1;

   initial begin
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;

      fill_desc(); set_entry(77, 8'd5);
      run_search(0, 0, 0, dc, rd, mc1);
      check("t1_done_cyc", dc, 31);
      check("t1_min", min_out, 5);
      check("t1_idx", idx_out, 77);
      check("t1_found", found_out, 1);
      check("t1_reads", (rd >= 26) && (rd <= 27), 1);

      fill_all(8'hFF);
      run_search(0, 0, 0, dc, rd, mc1);
      check("t2_done_cyc", dc, 20);
      check("t2_min", min_out, 8'hFF);
      check("t2_idx", idx_out, 0);
      check("t2_found", found_out, 0);
      check("t2_reads", rd, 16);

      fill_all(8'd50); set_entry(10, 8'd3); set_entry(90, 8'd3);
      run_search(0, 0, 0, dc, rd, mc1);
      check("t3_done_cyc", dc, 23);
      check("t3_min", min_out, 3);
      check("t3_idx", idx_out, 10);
      check("t3_found", found_out, 1);
      check("t3_reads", (rd >= 18) && (rd <= 19), 1);

      fill_desc(); set_entry(77, 8'd5);
      run_search(5, 12, 0, dc, rd, mc1);
      check("t4_done_cyc", dc, 31);
      check("t4_min_held", mc1, 3);
      check("t4_min", min_out, 5);
      check("t4_idx", idx_out, 77);

      fill_all(8'd60); set_entry(33, 8'd40);
      run_search(0, 0, 8, dc, rd, mc1);
      run_search(0, 0, 0, dc, rd, mc1);
      check("t5_done_cyc", dc, 26);
      check("t5_min", min_out, 40);
      check("t5_idx", idx_out, 33);
      check("t5_found", found_out, 1);

      fill_desc(); set_entry(127, 8'd1);
      run_search(0, 0, 0, dc, rd, mc1);
      check("t6_done_cyc", dc, 37);
      check("t6_min", min_out, 1);
      check("t6_idx", idx_out, 127);
      check("t6_found", found_out, 1);

      fill_all(8'hFF);
      @(negedge clk); start_in = 1'b1;
      @(posedge clk);
      n = 0;
      while (n < 200) begin @(negedge clk); n++; if (done_out) break; end
      check("t7_first_done", n, 20);
      @(negedge clk); n++;
      check("t7_idle_gap_busy", busy_out, 0);
      @(negedge clk); n++;
      check("t7_restart_busy", busy_out, 1);
      check("t7_restart_iniciar", bus.cmp_iniciar_out, 1);
      start_in = 1'b0;
      while (n < 200) begin @(negedge clk); n++; if (done_out) break; end
      check("t7_second_done", n, 41);
      check("t7_found", found_out, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
